// File: rtl/game_timer.sv
// Countdown game clock: prescales clk_sys-rate ticks into seconds, counts a BCD
// seconds value down to zero and flags expiry and a low-time warning.
module game_timer #(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int GAME_SECONDS  = 60,
    parameter int WARN_SECONDS  = 10
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       timer_enable,
    input  logic       reset_timer,
    output logic       timer_expires,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       tick_1s,
    output logic       warning
);

    localparam int             PW         = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0]  PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]     INIT_TENS  = 4'(GAME_SECONDS / 10);
    localparam logic [3:0]     INIT_ONES  = 4'(GAME_SECONDS % 10);
    localparam logic [6:0]     WARN_VAL   = 7'(WARN_SECONDS);

    logic [PW-1:0] r_presc;
    logic [3:0]    r_tens;
    logic [3:0]    r_ones;
    logic          r_expired;
    logic          r_tick;

    logic          w_last_sec;
    logic          w_wrap;
    logic [6:0]    w_value;

    assign w_last_sec = (r_tens == 4'd0) && (r_ones <= 4'd1);
    assign w_wrap     = (r_presc == PRESC_MAX);
    assign w_value    = (7'(r_tens) * 7'd10) + 7'(r_ones);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_presc   <= '0;
            r_tens    <= INIT_TENS;
            r_ones    <= INIT_ONES;
            r_expired <= 1'b0;
            r_tick    <= 1'b0;
        end else if (reset_timer) begin
            r_presc   <= '0;
            r_tens    <= INIT_TENS;
            r_ones    <= INIT_ONES;
            r_expired <= 1'b0;
            r_tick    <= 1'b0;
        end else if (r_expired) begin
            r_tick    <= 1'b0;
        end else if (timer_enable) begin
            if (w_wrap) begin
                r_presc <= '0;
                r_tick  <= 1'b1;
                // Last second lands on 0,0 and latches expiry on the same edge.
                if (w_last_sec) begin
                    r_tens    <= 4'd0;
                    r_ones    <= 4'd0;
                    r_expired <= 1'b1;
                end else if (r_ones != 4'd0) begin
                    r_ones <= r_ones - 4'd1;
                end else begin
                    r_ones <= 4'd9;
                    r_tens <= r_tens - 4'd1;
                end
            end else begin
                r_presc <= r_presc + 1'b1;
                r_tick  <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    // Mask hides the previous round's expiry while the controller reloads.
    assign timer_expires = r_expired & ~reset_timer;
    assign sec_tens      = r_tens;
    assign sec_ones      = r_ones;
    assign tick_1s       = r_tick;
    assign warning       = timer_enable & ~r_expired & (w_value <= WARN_VAL);

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: two instances (12 s and 99 s rounds) driven in lockstep
// and compared each cycle against an elapsed-ticks model.
module tb_game_timer;

    localparam int TPS = 4;

    logic       clk;
    logic       resetb;
    logic       timer_enable;
    logic       reset_timer;
    logic       timer_expires [2];
    logic [3:0] sec_tens      [2];
    logic [3:0] sec_ones      [2];
    logic       tick_1s       [2];
    logic       warning       [2];

    int checks   = 0;
    int failures = 0;
    int m_el     [2];
    bit m_tick   [2];

    game_timer #(.TICKS_PER_SEC(TPS), .GAME_SECONDS(12), .WARN_SECONDS(3)) dut0 (
        .clk           (clk),
        .resetb        (resetb),
        .timer_enable  (timer_enable),
        .reset_timer   (reset_timer),
        .timer_expires (timer_expires[0]),
        .sec_tens      (sec_tens[0]),
        .sec_ones      (sec_ones[0]),
        .tick_1s       (tick_1s[0]),
        .warning       (warning[0])
    );

    game_timer #(.TICKS_PER_SEC(TPS), .GAME_SECONDS(99), .WARN_SECONDS(10)) dut1 (
        .clk           (clk),
        .resetb        (resetb),
        .timer_enable  (timer_enable),
        .reset_timer   (reset_timer),
        .timer_expires (timer_expires[1]),
        .sec_tens      (sec_tens[1]),
        .sec_ones      (sec_ones[1]),
        .tick_1s       (tick_1s[1]),
        .warning       (warning[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int game_of(input int i);
        return (i == 0) ? 12 : 99;
    endfunction

    function automatic int warn_of(input int i);
        return (i == 0) ? 3 : 10;
    endfunction

    function automatic bit m_exp(input int i);
        return m_el[i] >= game_of(i) * TPS;
    endfunction

    function automatic int m_rem(input int i);
        return game_of(i) - (m_el[i] / TPS);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_el[i]   = 0;
            m_tick[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!resetb || reset_timer) begin
                m_el[i]   = 0;
                m_tick[i] = 1'b0;
            end else if (m_exp(i)) begin
                m_tick[i] = 1'b0;
            end else if (timer_enable) begin
                m_el[i]   = m_el[i] + 1;
                m_tick[i] = ((m_el[i] % TPS) == 0);
            end else begin
                m_tick[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("tens%0d", i), 32'(sec_tens[i]), 32'(m_rem(i) / 10));
            chk($sformatf("ones%0d", i), 32'(sec_ones[i]), 32'(m_rem(i) % 10));
            chk($sformatf("tick%0d", i), 32'(tick_1s[i]), 32'(m_tick[i]));
            chk($sformatf("expires%0d", i), 32'(timer_expires[i]),
                32'(m_exp(i) && !reset_timer));
            chk($sformatf("warning%0d", i), 32'(warning[i]),
                32'(timer_enable && !m_exp(i) && (m_rem(i) <= warn_of(i))));
        end
    endtask

    task automatic step(input bit en, input bit rt);
        @(negedge clk);
        timer_enable = en;
        reset_timer  = rt;
        #1;
        for (int i = 0; i < 2; i++)
            chk($sformatf("pre_mask%0d", i), 32'(timer_expires[i]), 32'(m_exp(i) && !rt));
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetb       = 1'b0;
        timer_enable = 1'b0;
        reset_timer  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetb = 1'b1;
        #1;
        check_all();

        // Idle after reset: full round shown, nothing moves.
        for (int c = 0; c < 20; c++) step(1'b0, 1'b0);
        chk("t1_tens", 32'(sec_tens[0]), 32'd1);
        chk("t1_ones", 32'(sec_ones[0]), 32'd2);
        chk("t1_tens99", 32'(sec_tens[1]), 32'd9);

        // Full 12 s round.
        step(1'b1, 1'b1);
        for (int e = 1; e <= 48; e++) begin
            step(1'b1, 1'b0);
            if (e == 4) begin
                chk("t2_tick4", 32'(tick_1s[0]), 32'd1);
                chk("t2_ones4", 32'(sec_ones[0]), 32'd1);
            end
            if (e == 12) begin
                chk("t2_borrow_tens", 32'(sec_tens[0]), 32'd0);
                chk("t2_borrow_ones", 32'(sec_ones[0]), 32'd9);
            end
            if (e == 35) chk("t2_warn35", 32'(warning[0]), 32'd0);
            if (e == 36) chk("t2_warn36", 32'(warning[0]), 32'd1);
            if (e == 47) chk("t2_exp47", 32'(timer_expires[0]), 32'd0);
        end
        chk("t2_exp48", 32'(timer_expires[0]), 32'd1);
        chk("t2_ones48", 32'(sec_ones[0]), 32'd0);
        for (int c = 0; c < 8; c++) step(1'b1, 1'b0);

        // Reload after expiry: masked in the reload cycle itself.
        @(negedge clk);
        reset_timer = 1'b1;
        #1;
        chk("t4_mask", 32'(timer_expires[0]), 32'd0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("t4_tens", 32'(sec_tens[0]), 32'd1);
        chk("t4_ones", 32'(sec_ones[0]), 32'd2);

        // Pause at 0,7 with presc=2.
        step(1'b1, 1'b1);
        for (int e = 0; e < 22; e++) step(1'b1, 1'b0);
        for (int c = 0; c < 10; c++) step(1'b0, 1'b0);
        chk("t3_pause_ones", 32'(sec_ones[0]), 32'd7);
        chk("t3_pause_warn", 32'(warning[0]), 32'd0);
        step(1'b1, 1'b0);
        chk("t3_resume1_tick", 32'(tick_1s[0]), 32'd0);
        step(1'b1, 1'b0);
        chk("t3_resume2_tick", 32'(tick_1s[0]), 32'd1);
        chk("t3_resume2_ones", 32'(sec_ones[0]), 32'd6);

        // Reload colliding with the terminal tick.
        step(1'b1, 1'b1);
        for (int e = 0; e < 47; e++) step(1'b1, 1'b0);
        chk("t5_pre_ones", 32'(sec_ones[0]), 32'd1);
        step(1'b1, 1'b1);
        chk("t5_tick", 32'(tick_1s[0]), 32'd0);
        chk("t5_exp", 32'(timer_expires[0]), 32'd0);
        chk("t5_ones", 32'(sec_ones[0]), 32'd2);

        // Asynchronous reset mid-round at 0,5.
        step(1'b1, 1'b1);
        for (int e = 0; e < 28; e++) step(1'b1, 1'b0);
        chk("t6_pre_ones", 32'(sec_ones[0]), 32'd5);
        @(negedge clk);
        resetb = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_tens", 32'(sec_tens[0]), 32'd1);
        chk("t6_rst_ones", 32'(sec_ones[0]), 32'd2);
        chk("t6_rst_tick", 32'(tick_1s[0]), 32'd0);
        chk("t6_rst_exp", 32'(timer_expires[0]), 32'd0);
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
        resetb = 1'b1;

        // 99 s round expires on enabled edge 396.
        step(1'b1, 1'b1);
        for (int e = 0; e < 395; e++) step(1'b1, 1'b0);
        chk("t6_99_exp395", 32'(timer_expires[1]), 32'd0);
        step(1'b1, 1'b0);
        chk("t6_99_exp396", 32'(timer_expires[1]), 32'd1);
        chk("t6_99_tens", 32'(sec_tens[1]), 32'd0);

        // Random enable/reload traffic against the model.
        for (int c = 0; c < 300; c++)
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Countdown game clock for the code-breaking game.
- Driven by the game controller's timer_enable and reset_timer; returns timer_expires to it, which ends a round.
- Also exports the remaining seconds as two BCD digits and a low-time warning for the seven-segment and LED display stage.
- One instance per design, in the top level beside the game controller.

Parameters:
- TICKS_PER_SEC, 100000000: clk cycles per game second; legal range 2..2^27.
- GAME_SECONDS, 60: round length in seconds, loaded on reset_timer; legal range 1..99.
- WARN_SECONDS, 10: warning threshold in seconds; legal range 0..GAME_SECONDS.

Ports:
- clk  input  1  system clock.
- resetb  input  1  asynchronous active-low reset.
- timer_enable  input  1  level; 1 = count, 0 = pause.
- reset_timer  input  1  synchronous reload request; normally one cycle wide.
- timer_expires  output  1  level; time exhausted.
- sec_tens  output  4  BCD tens digit of remaining seconds.
- sec_ones  output  4  BCD ones digit of remaining seconds.
- tick_1s  output  1  one-cycle pulse on each second decrement.
- warning  output  1  remaining time is at or below WARN_SECONDS while running.

Behaviour:
- Internal registers:
  - presc: ceil(log2(TICKS_PER_SEC)) bits.
  - tens_q, ones_q: BCD.
  - expired_q.
- Async reset (resetb=0):
  - presc=0; tens_q/ones_q = BCD of GAME_SECONDS; expired_q=0; tick_1s=0.
  - Outputs therefore show the full round time, timer_expires=0, warning=0.
- Priority per rising edge: reset_timer > expired hold > enabled count > pause.
- reset_timer=1:
  - presc=0; digits reload to GAME_SECONDS; expired_q=0; tick_1s=0.
  - This applies regardless of timer_enable.
- expired_q=1 and reset_timer=0:
  - All state holds; digits stay 0,0; no ticks.
- timer_enable=1, reset_timer=0, expired_q=0:
  - If presc < TICKS_PER_SEC-1: presc increments.
  - Else: presc wraps to 0, tick_1s=1 for one cycle, and the BCD value decrements:
    - ones_q != 0: ones_q - 1.
    - ones_q == 0: ones_q = 9, tens_q - 1.
  - If the pre-decrement value is 0,1, expired_q is set on the same edge. The digits become 0,0 at that same edge.
- timer_enable=0 (pause): presc, digits and expired_q freeze; tick_1s=0. Counting resumes from the frozen presc, so no partial second is lost.
- First tick after reload: on the TICKS_PER_SEC-th enabled edge after the reload edge. Expiry: on the (GAME_SECONDS*TICKS_PER_SEC)-th enabled edge after the reload edge.
- timer_expires = expired_q AND NOT reset_timer (combinational mask).
  - Required so the controller never sees a stale expiry from the previous round.
  - The controller enters its run state on the same edge it raises reset_timer.
- warning = timer_enable AND NOT expired_q AND (value <= WARN_SECONDS). Combinational from registers; WARN_SECONDS=0 means warning never asserts.
- sec_tens/sec_ones are direct register outputs, with no decode latency.
- reset_timer held for multiple cycles: the timer stays at the loaded value; counting starts on the first edge after it drops.
- Simultaneous reset_timer and a terminal tick: reload wins, no tick_1s, no expiry.
- resetb asserted mid-round: immediate return to reset values; the next round requires a reset_timer or a fresh count from the reset state if enabled.
- Digits never underflow below 0,0, and presc never exceeds TICKS_PER_SEC-1.

Test Plan: (TICKS_PER_SEC=4, GAME_SECONDS=12, WARN_SECONDS=3 unless noted)
1. Reset release with timer_enable=0 for 20 cycles -> sec_tens=1, sec_ones=2, timer_expires=0, warning=0, tick_1s never pulses.
2. One cycle of reset_timer=1 with timer_enable=1, then enable held -> tick_1s on enabled edges 4,8,12,...; digits 1,1 after edge 4, then 1,0 at 8, then 0,9 at 12 (BCD borrow); warning rises when the value reaches 3 (edge 36); timer_expires=1 with digits 0,0 at edge 48; state is then held with no further ticks.
3. Run to 0,7 with presc=2, drop timer_enable for 10 cycles, then re-raise -> digits and presc frozen, warning=0 while paused; next tick arrives exactly 2 enabled edges after resume, giving 0,6.
4. After expiry, drive reset_timer=1 for one cycle -> timer_expires reads 0 during that same cycle (mask) and stays 0 afterwards; digits reload to 1,2.
5. reset_timer asserted on the edge where presc=3 and value=0,1 -> no tick_1s, expired_q stays 0, digits 1,2.
6. resetb pulsed low mid-round at 0,5 -> outputs immediately show 1,2, timer_expires=0, tick_1s=0. Run one case with GAME_SECONDS=99 -> reset shows 9,9 and expiry occurs at edge 396.
